// File: rtl/vcontrol_pipe.sv
// Vector-capable control unit: decodes in D, sequences multipass vector ops
// into E one pass per cycle, and carries controls through E->M->W.
module vcontrol_pipe #(
  parameter int VLEN  = 8,
  parameter int LANES = 4,
  localparam int PASSES = VLEN / LANES,
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opD,
  input  logic [5:0]    functD,
  input  logic          eqD,
  input  logic          flushE,
  output logic          stallD,
  output logic          pcsrcD,
  output logic          jumpD,
  output logic [1:0]    branchD,
  output logic          alusrcE,
  output logic          scalarE,
  output logic          regdstE,
  output logic          regwriteE,
  output logic          memtoregE,
  output logic [3:0]    alucontrolE,
  output logic [PW-1:0] passE,
  output logic          lastpassE,
  output logic          memwriteM,
  output logic          regwriteM,
  output logic          memtoregM,
  output logic          regwriteW,
  output logic          vregwriteW,
  output logic          memtoregW
);

  typedef struct packed {
    logic       alusrc;
    logic       scalar;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       vregwrite;
    logic [3:0] alu;
  } ctrl_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  ctrl_t          dec;
  logic           multi;
  ctrl_t          e_d, e_q, hold_d, hold_q;
  logic [PW-1:0]  pass_d, pass_q, cnt_d, cnt_q;
  logic           last_d, last_q;
  state_t         state_d, state_q;
  logic [3:0]     m_d, m_q;
  logic [2:0]     w_d, w_q;
  logic           unused_funct;

  assign unused_funct = ^functD[5:4];

  always_comb begin
    dec     = '0;
    multi   = 1'b0;
    branchD = 2'b00;
    jumpD   = 1'b0;
    case (opD)
      6'b000000: begin dec.regwrite = 1'b1; dec.regdst = 1'b1; dec.alu = functD[3:0]; end
      6'b000100: begin dec.vregwrite = 1'b1; dec.alu = functD[3:0]; multi = 1'b1; end
      6'b001100: begin
        dec.vregwrite = 1'b1; dec.scalar = 1'b1; dec.alu = functD[3:0]; multi = 1'b1;
      end
      6'b010000: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      6'b100000: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.memtoreg = 1'b1; end
      6'b100001: begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      6'b100010: begin
        dec.vregwrite = 1'b1; dec.alusrc = 1'b1; dec.memtoreg = 1'b1; multi = 1'b1;
      end
      6'b110001: branchD = 2'b01;
      6'b110010: branchD = 2'b10;
      6'b111111: jumpD = 1'b1;
      default: ;
    endcase
  end

  assign pcsrcD = ((branchD == 2'b01) & eqD) | ((branchD == 2'b10) & ~eqD);

  // Later passes replay the controls captured at sequence start, not live D.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    e_d     = dec;
    pass_d  = '0;
    last_d  = 1'b0;
    stallD  = 1'b0;
    case (state_q)
      IDLE: begin
        if (multi) begin
          if (PASSES > 1) begin
            state_d = ISSUE;
            cnt_d   = PW'(1);
            hold_d  = dec;
            stallD  = 1'b1;
          end else begin
            last_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        e_d    = hold_q;
        pass_d = cnt_q;
        if (cnt_q == LAST_PASS) begin
          last_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + PW'(1);
          stallD = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flushE) begin
      e_d     = '0;
      pass_d  = '0;
      last_d  = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end
    if (!reset) stallD = 1'b0;
  end

  always_comb begin
    m_d = {e_q.memwrite, e_q.regwrite, e_q.memtoreg, e_q.vregwrite};
    w_d = {m_q[2], m_q[0], m_q[1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q     <= '0;
      hold_q  <= '0;
      pass_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      e_q     <= e_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      m_q     <= m_d;
      w_q     <= w_d;
    end
  end

  assign alusrcE     = e_q.alusrc;
  assign scalarE     = e_q.scalar;
  assign regdstE     = e_q.regdst;
  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign alucontrolE = e_q.alu;
  assign passE       = pass_q;
  assign lastpassE   = last_q;

  assign memwriteM = m_q[3];
  assign regwriteM = m_q[2];
  assign memtoregM = m_q[1];

  assign regwriteW  = w_q[2];
  assign vregwriteW = w_q[1];
  assign memtoregW  = w_q[0];

endmodule
